// File: rtl/bpsk_demodulator.sv
// BPSK correlating demodulator: multiplies each accepted sample by a recursive-oscillator
// reference sine, integrates over a symbol and slices the sign into a recovered bit.
module bpsk_demodulator #(
  parameter int SYMBOL_LEN = 64,
  parameter int ACC_W      = 24,
  parameter int THRESH     = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sync,
  input  logic                    sample_valid,
  input  logic signed [7:0]       wave,
  output logic                    bit_out,
  output logic                    bit_valid,
  output logic                    bit_weak,
  output logic signed [ACC_W-1:0] acc_out,
  output logic signed [7:0]       ref_out
);

  localparam int CNT_W = $clog2(SYMBOL_LEN + 1);

  typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_t;

  state_t                  state_reg, state_next;
  logic [CNT_W-1:0]        cnt_reg, cnt_next;
  logic signed [ACC_W-1:0] acc_reg, acc_next;
  logic signed [15:0]      sine_reg, cos_reg;
  logic signed [15:0]      sine_step, cos_step;
  logic                    bit_out_reg, bit_out_next;
  logic                    bit_valid_reg, bit_valid_next;
  logic                    bit_weak_reg, bit_weak_next;
  logic signed [ACC_W-1:0] acc_out_reg, acc_out_next;

  logic signed [15:0]      product;
  logic signed [ACC_W-1:0] product_ext;
  logic signed [ACC_W-1:0] final_sum;
  logic signed [ACC_W-1:0] final_abs;
  logic                    final_weak;
  logic                    last_sample;

  // Coupled oscillator: the cosine update uses the freshly computed sine.
  assign sine_step = sine_reg + (cos_reg >>> 6);
  assign cos_step  = cos_reg - (sine_step >>> 6);

  assign ref_out     = sine_reg[15:8];
  assign product     = wave * ref_out;
  assign product_ext = ACC_W'(product);
  assign final_sum   = acc_reg + product_ext;
  assign final_abs   = final_sum[ACC_W-1] ? -final_sum : final_sum;
  // A negated most-negative value stays negative, which is deliberately treated as strong.
  assign final_weak  = !final_abs[ACC_W-1] && (final_abs < ACC_W'(THRESH));
  assign last_sample = (cnt_reg == CNT_W'(SYMBOL_LEN - 1));

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    acc_next       = acc_reg;
    bit_out_next   = bit_out_reg;
    bit_valid_next = 1'b0;
    bit_weak_next  = bit_weak_reg;
    acc_out_next   = acc_out_reg;

    if (sync) begin
      state_next = IDLE;
      cnt_next   = '0;
      acc_next   = '0;
      if (sample_valid) begin
        state_next = ACCUM;
        cnt_next   = CNT_W'(1);
        acc_next   = product_ext;
      end
    end else begin
      case (state_reg)
        IDLE: begin
          if (sample_valid) begin
            state_next = ACCUM;
            cnt_next   = CNT_W'(1);
            acc_next   = product_ext;
          end
        end
        ACCUM: begin
          if (sample_valid) begin
            if (last_sample) begin
              state_next     = EMIT;
              cnt_next       = '0;
              acc_next       = '0;
              acc_out_next   = final_sum;
              bit_out_next   = ~final_sum[ACC_W-1];
              bit_weak_next  = final_weak;
              bit_valid_next = 1'b1;
            end else begin
              cnt_next = cnt_reg + CNT_W'(1);
              acc_next = final_sum;
            end
          end
        end
        EMIT: begin
          // A sample arriving during the strobe opens the next symbol.
          state_next = ACCUM;
          if (sample_valid) begin
            cnt_next = CNT_W'(1);
            acc_next = product_ext;
          end else begin
            cnt_next = '0;
            acc_next = '0;
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
          acc_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      acc_reg       <= '0;
      sine_reg      <= 16'sd0;
      cos_reg       <= 16'sd30000;
      bit_out_reg   <= 1'b0;
      bit_valid_reg <= 1'b0;
      bit_weak_reg  <= 1'b0;
      acc_out_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      acc_reg       <= acc_next;
      bit_out_reg   <= bit_out_next;
      bit_valid_reg <= bit_valid_next;
      bit_weak_reg  <= bit_weak_next;
      acc_out_reg   <= acc_out_next;
      if (sample_valid) begin
        sine_reg <= sine_step;
        cos_reg  <= cos_step;
      end
    end
  end

  assign bit_out   = bit_out_reg;
  assign bit_valid = bit_valid_reg;
  assign bit_weak  = bit_weak_reg;
  assign acc_out   = acc_out_reg;

endmodule

// File: tb/tb_bpsk_demodulator.sv
// Bench for bpsk_demodulator: a 64-sample instance checked against a sample-count model,
// plus a 2-sample instance for the short directed symbols.
module tb_bpsk_demodulator;

  localparam int ACC_W  = 24;
  localparam int THRESH = 1024;
  localparam int L      = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic              sync = 1'b0, sample_valid = 1'b0;
  logic signed [7:0] wave = '0;
  logic              bit_out, bit_valid, bit_weak;
  logic signed [ACC_W-1:0] acc_out;
  logic signed [7:0] ref_out;

  logic              sync2 = 1'b0, sample_valid2 = 1'b0;
  logic signed [7:0] wave2 = '0;
  logic              bit_out2, bit_valid2, bit_weak2;
  logic signed [ACC_W-1:0] acc_out2;
  logic signed [7:0] ref_out2;

  bpsk_demodulator #(.SYMBOL_LEN(L), .ACC_W(ACC_W), .THRESH(THRESH)) dut (
    .clk(clk), .rst(rst), .sync(sync), .sample_valid(sample_valid), .wave(wave),
    .bit_out(bit_out), .bit_valid(bit_valid), .bit_weak(bit_weak),
    .acc_out(acc_out), .ref_out(ref_out)
  );

  bpsk_demodulator #(.SYMBOL_LEN(2), .ACC_W(ACC_W), .THRESH(THRESH)) dut2 (
    .clk(clk), .rst(rst), .sync(sync2), .sample_valid(sample_valid2), .wave(wave2),
    .bit_out(bit_out2), .bit_valid(bit_valid2), .bit_weak(bit_weak2),
    .acc_out(acc_out2), .ref_out(ref_out2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int strobes = 0;

  // Reference model: oscillator as integers, correlation as an unbounded sum wrapped at symbol end.
  int     m_sin, m_cos, m_cnt;
  longint m_acc;
  longint exp_bv, exp_bit, exp_weak, exp_acc;
  longint c3_acc_a, c3_acc_b;

  function automatic int wrap16(input int x);
    shortint t;
    t = shortint'(x);
    return int'(t);
  endfunction

  function automatic longint wrap_acc(input longint x);
    longint m;
    m = x & ((64'sd1 <<< ACC_W) - 1);
    if (m >= (64'sd1 <<< (ACC_W - 1))) m = m - (64'sd1 <<< ACC_W);
    return m;
  endfunction

  function automatic int mref();
    return m_sin >>> 8;
  endfunction

  task automatic model_reset();
    m_sin = 0; m_cos = 30000; m_cnt = 0; m_acc = 0;
    exp_bv = 0; exp_bit = 0; exp_weak = 0; exp_acc = 0;
  endtask

  task automatic model_step(input bit r, input bit v, input bit s, input int w);
    longint fin;
    int ns;
    if (r) begin
      model_reset();
      return;
    end
    exp_bv = 0;
    if (s) begin
      m_cnt = 0; m_acc = 0;
    end
    if (v) begin
      m_acc += longint'(w * mref());
      m_cnt++;
      if (m_cnt == L) begin
        fin      = wrap_acc(m_acc);
        exp_acc  = fin;
        exp_bit  = (fin >= 0) ? 1 : 0;
        exp_weak = (fin > -THRESH && fin < THRESH) ? 1 : 0;
        exp_bv   = 1;
        m_cnt = 0; m_acc = 0;
      end
      ns    = wrap16(m_sin + (m_cos >>> 6));
      m_cos = wrap16(m_cos - (ns >>> 6));
      m_sin = ns;
    end
  endtask

  task automatic check(input string tag, input longint obs, input longint expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, expv);
    end
  endtask

  // One clock of the 64-sample instance; all outputs compared after the edge.
  task automatic step(input bit r, input bit v, input bit s, input int w);
    @(negedge clk);
    rst = r; sample_valid = v; sync = s; wave = 8'(w);
    sync2 = 1'b0; sample_valid2 = 1'b0;
    if (!r) check("ref_out", longint'(ref_out), longint'(mref()));
    model_step(r, v, s, w);
    @(posedge clk);
    #1;
    check("bit_valid", longint'(bit_valid), exp_bv);
    check("acc_out", longint'(acc_out), exp_acc);
    check("bit_out", longint'(bit_out), exp_bit);
    check("bit_weak", longint'(bit_weak), exp_weak);
    if (bit_valid) strobes++;
  endtask

  task automatic step2(input bit v, input int w);
    @(negedge clk);
    rst = 1'b0; sample_valid = 1'b0; sync = 1'b0;
    sample_valid2 = v; wave2 = 8'(w); sync2 = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int s0;
    model_reset();
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check("reset_ref_out", longint'(ref_out), 0);
    check("reset_bit_valid2", longint'(bit_valid2), 0);
    check("reset_acc_out2", longint'(acc_out2), 0);

    // Short symbol, positive wave.
    step2(1, 100);
    check("c1_no_early_strobe", longint'(bit_valid2), 0);
    step2(1, 100);
    check("c1_strobe", longint'(bit_valid2), 1);
    check("c1_acc", longint'(acc_out2), 100);
    check("c1_bit", longint'(bit_out2), 1);
    check("c1_weak", longint'(bit_weak2), 1);
    step2(0, 0);
    check("c1_strobe_one_cycle", longint'(bit_valid2), 0);
    check("c1_acc_hold", longint'(acc_out2), 100);

    // Short symbol, negative wave.
    step(1, 0, 0, 0);
    step2(1, -100);
    step2(1, -100);
    check("c2_strobe", longint'(bit_valid2), 1);
    check("c2_acc", longint'(acc_out2), -100);
    check("c2_bit", longint'(bit_out2), 0);
    check("c2_weak", longint'(bit_weak2), 1);

    // Matched reference: +ref then -ref, back to back.
    step(1, 0, 0, 0);
    strobes = 0;
    for (int i = 0; i < L; i++) step(0, 1, 0, mref());
    check("c3_bit1", longint'(bit_out), 1);
    check("c3_weak1", longint'(bit_weak), 0);
    c3_acc_a = exp_acc;
    for (int i = 0; i < L; i++) step(0, 1, 0, -mref());
    check("c3_bit0", longint'(bit_out), 0);
    check("c3_weak0", longint'(bit_weak), 0);
    c3_acc_b = exp_acc;
    check("c3_strobe_count", strobes, 2);

    // All-zero symbol.
    step(1, 0, 0, 0);
    for (int i = 0; i < L; i++) step(0, 1, 0, 0);
    check("c4_acc", longint'(acc_out), 0);
    check("c4_bit", longint'(bit_out), 1);
    check("c4_weak", longint'(bit_weak), 1);

    // Sparse valid: same result as continuous.
    step(1, 0, 0, 0);
    for (int i = 0; i < 2 * L; i++) begin
      step(0, 1, 0, (i < L) ? mref() : -mref());
      if (i == L - 1) check("c5_acc_a", longint'(acc_out), c3_acc_a);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
    end
    check("c5_acc_b", longint'(acc_out), c3_acc_b);

    // Reset mid-symbol, then sync with a sample.
    step(1, 0, 0, 0);
    strobes = 0;
    for (int i = 0; i < 29; i++) step(0, 1, 0, mref());
    step(1, 0, 0, 0);
    check("c6_ref_after_rst", longint'(ref_out), 0);
    check("c6_no_strobe", strobes, 0);
    for (int i = 0; i < L; i++) step(0, 1, 0, mref());
    check("c6_acc_after_rst", longint'(acc_out), c3_acc_a);
    for (int i = 0; i < 9; i++) step(0, 1, 0, 50);
    step(0, 1, 1, 50);
    s0 = strobes;
    for (int i = 0; i < 62; i++) step(0, 1, 0, 50);
    check("c6_no_strobe_before_63", strobes - s0, 0);
    step(0, 1, 0, 50);
    check("c6_strobe_at_63", strobes - s0, 1);

    // Randomized traffic with sparse valid, occasional sync and reset.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 499) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 149) == 0), int'($urandom_range(0, 255)) - 128);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bpsk_demodulator.md
Name: bpsk_demodulator

Overview:
- Receive end of the modulated square-wave link. Accepts signed 8-bit modulated samples and correlates each against a locally generated reference sine.
- The reference sine comes from the same recursive oscillator the modulator uses: 16-bit, shift-6 coupled update, seeded 0/30000.
- At the end of each symbol the sign of the correlation gives the recovered data bit, i.e. the modulator's cout[0].
- Sits between the sample source (ADC or modulator loopback) and the bit sink.

Parameters:
- SYMBOL_LEN, 64, samples per symbol; must be at least 2.
- ACC_W, 24, correlator accumulator width, two's complement.
- THRESH, 1024, |correlation| below this marks the bit weak.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- sync  in  1  symbol-boundary resync pulse.
- sample_valid  in  1  wave is valid this cycle.
- wave  in  8  signed modulated sample.
- bit_out  out  1  recovered bit.
- bit_valid  out  1  one-cycle strobe: bit_out, bit_weak and acc_out are new.
- bit_weak  out  1  correlation magnitude < THRESH.
- acc_out  out  ACC_W  final correlation of the last symbol.
- ref_out  out  8  current reference sample, for debug.

Behaviour:
- One clock; reset is synchronous and active-high. Ports are clk and rst.
- Reset values:
  - state = IDLE, cnt = 0, acc = 0.
  - sine_r = 0, cos_r = 30000.
  - bit_out = 0, bit_valid = 0, bit_weak = 0, acc_out = 0.
  - ref_out = sine_r[15:8] = 0.
- Oscillator advances only on cycles with sample_valid = 1, in this order:
  - s = sine_r + (cos_r >>> 6)
  - c = cos_r − (s >>> 6), using the new s.
  - sine_r <= s; cos_r <= c.
  - All arithmetic is 16-bit signed and wraps.
- Reference for an accepted sample is ref = sine_r[15:8], the pre-update register value.
  - The first sample after reset therefore multiplies by 0; refs then run 1, 3, …
- Product p = wave × ref, signed 8×8 → 16 bits, sign-extended to ACC_W.
- The accumulator wraps at ACC_W; no saturation.
- FSM states:
  - IDLE, no symbol in progress: on sample_valid → acc = p, cnt = 1, go to ACCUM.
  - ACCUM: on sample_valid → acc += p, cnt += 1. When the accepted sample is number SYMBOL_LEN:
    - final = acc + p;
    - acc_out <= final; bit_out <= ~final[ACC_W−1] (≥ 0 → 1);
    - bit_weak <= (|final| < THRESH); bit_valid <= 1;
    - acc, cnt <= 0; go to EMIT.
  - EMIT: bit_valid is high for exactly this cycle. Go to ACCUM.
    - A sample_valid in EMIT is the first sample of the next symbol: acc = p, cnt = 1. No sample is dropped.
- Latency: bit_valid rises in the cycle after the clock edge that accepts the last sample of the symbol.
- Gaps in sample_valid stall cnt, acc and the oscillator. Outputs are held.
- sync:
  - At the edge: state <= IDLE, acc <= 0, cnt <= 0, bit_valid <= 0. The oscillator is not reset.
  - sync together with sample_valid: the sample is taken as the first sample of a new symbol (acc = p, cnt = 1, state ACCUM) and the oscillator advances.
  - sync in EMIT: the current strobe cycle is unaffected; the next cycle follows the sync rules.
- rst has priority over sync and sample_valid. Reset mid-symbol discards the partial correlation, and no bit_valid is produced.
- bit_out, bit_weak and acc_out hold their values between strobes.
- |final| uses two's-complement negate. The most-negative value counts as not weak.

Test Plan:
1. SYMBOL_LEN = 2; after reset, wave = 100 on two consecutive valid cycles → refs 0, 1; acc_out = 100, bit_out = 1, bit_weak = 1; bit_valid high one cycle, the cycle after the second sample.
2. Same as 1 with wave = −100 → acc_out = −100, bit_out = 0, bit_weak = 1.
3. SYMBOL_LEN = 64; drive wave = ref_out for 64 samples, then wave = −ref_out for 64 samples, continuously valid → bits 1 then 0, bit_weak = 0 both times; second symbol starts in the EMIT cycle with no lost sample; exactly 2 strobes 64 samples apart.
4. All samples 0 for one symbol → acc_out = 0, bit_out = 1, bit_weak = 1.
5. Valid every third cycle → same acc_out and bits as case 3; the oscillator sequence (ref_out 0, 1, 3, …) depends only on the accepted-sample count.
6. Assert rst at sample 30 of 64, then resume → no strobe for the aborted symbol; ref_out = 0 and the first post-reset symbol matches case 3. Pulse sync with sample_valid at sample 10 → that sample starts the new symbol; the next strobe comes 63 accepted samples later.
